// File: rtl/dff_bank_pkg.sv
// Shared definitions for the two-requester flip-flop bank arbiter.
// Holds the arbiter state encoding and the default bank geometry.
package dff_bank_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    PRI0  = 2'd0,
    PRI1  = 2'd1,
    LOCK0 = 2'd2,
    LOCK1 = 2'd3
  } arb_state_e;

endpackage

// File: rtl/dff_reg_bank.sv
// DEPTH x WIDTH register bank built from plain D flip-flops.
// One write port and one registered read port.
module dff_reg_bank
  import dff_bank_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // NOTE: the array is real flops with a defined reset value, so every entry
  // is cleared here; a RAM-style array would be left out of the reset branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // rdata only moves on a read and otherwise holds the last value returned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter with lock that shares one flip-flop register bank
// between two requesters; one access (read or write) per clock.
module dff_bank_arbiter
  import dff_bank_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic             lock0,
  input  logic             lock1,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata
);

  arb_state_e r_state;
  arb_state_e w_state_next;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_we;
  logic             w_re;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_wdata;
  logic             r_rvalid0;
  logic             r_rvalid1;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PRI0;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    w_state_next = r_state;

    unique case (r_state)
      PRI0: begin
        w_gnt0 = req0;
        w_gnt1 = req1 & ~req0;
      end
      PRI1: begin
        w_gnt1 = req1;
        w_gnt0 = req0 & ~req1;
      end
      LOCK0:   w_gnt0 = req0;
      LOCK1:   w_gnt1 = req1;
      default: ;
    endcase

    if (w_gnt0) begin
      w_state_next = lock0 ? LOCK0 : PRI1;
    end else if (w_gnt1) begin
      w_state_next = lock1 ? LOCK1 : PRI0;
    end else if (r_state == LOCK0) begin
      w_state_next = PRI1;  // owner went idle: lock released to the other side
    end else if (r_state == LOCK1) begin
      w_state_next = PRI0;
    end
  end

  // At most one grant is high, so a simple mux steers the bank port.
  assign w_addr  = w_gnt1 ? addr1  : addr0;
  assign w_wdata = w_gnt1 ? wdata1 : wdata0;
  assign w_we    = (w_gnt0 & we0) | (w_gnt1 & we1);
  assign w_re    = (w_gnt0 & ~we0) | (w_gnt1 & ~we1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~we0;
      r_rvalid1 <= w_gnt1 & ~we1;
    end
  end

  dff_reg_bank #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_we),
    .waddr (w_addr),
    .wdata (w_wdata),
    .re    (w_re),
    .raddr (w_addr),
    .rdata (rdata)
  );

  assign gnt0    = w_gnt0;
  assign gnt1    = w_gnt1;
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter: reset, single access, round-robin,
// lock, lock release by idle and reset in the middle of a read.
module tb_dff_bank_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0, req1, we0, we1, lock0, lock1;
  logic [1:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  dff_bank_arbiter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .req1    (req1),
    .we0     (we0),
    .we1     (we1),
    .lock0   (lock0),
    .lock1   (lock1),
    .addr0   (addr0),
    .addr1   (addr1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .rvalid0 (rvalid0),
    .rvalid1 (rvalid1),
    .rdata   (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are then stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational grants settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    lock0 = 1'b0; lock1 = 1'b0;
    addr0 = 2'd0; addr1 = 2'd0; wdata0 = 8'h00; wdata1 = 8'h00;

    // Reset then idle
    tick(); tick();
    check("rst_rdata", 32'(rdata), 32'h00);
    check("rst_rvalid0", 32'(rvalid0), 32'd0);
    check("rst_rvalid1", 32'(rvalid1), 32'd0);
    req0 = 1'b1; req1 = 1'b1; settle();
    check("rst_gnt0_pri0", 32'(gnt0), 32'd1);
    check("rst_gnt1_pri0", 32'(gnt1), 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b1;
    tick();

    for (int a = 0; a < 4; a++) begin
      req0 = 1'b1; we0 = 1'b0; addr0 = 2'(a); settle();
      check("idle_rd_gnt0", 32'(gnt0), 32'd1);
      tick();
      check("idle_rd_rvalid0", 32'(rvalid0), 32'd1);
      check("idle_rd_rdata", 32'(rdata), 32'h00);
    end
    req0 = 1'b0; tick();
    check("idle_rvalid0_drop", 32'(rvalid0), 32'd0);

    // Single requester write then read-after-write
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd2; wdata0 = 8'hA5; settle();
    check("wr_gnt0", 32'(gnt0), 32'd1);
    tick();
    check("wr_no_rvalid0", 32'(rvalid0), 32'd0);
    we0 = 1'b0; settle();
    check("rd_gnt0", 32'(gnt0), 32'd1);
    tick();
    check("raw_rvalid0", 32'(rvalid0), 32'd1);
    check("raw_rdata", 32'(rdata), 32'hA5);
    req0 = 1'b0; tick();

    // Contention round-robin from reset
    rst_n = 1'b0; tick(); tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 2'd0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 2'd1;
    rst_n = 1'b1; settle();
    for (int i = 0; i < 4; i++) begin
      check("rr_gnt0", 32'(gnt0), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_gnt1", 32'(gnt1), (i % 2 == 0) ? 32'd0 : 32'd1);
      check("rr_exclusive", 32'(gnt0 & gnt1), 32'd0);
      tick();
      check("rr_rvalid0", 32'(rvalid0), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_rvalid1", 32'(rvalid1), (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    req0 = 1'b0; req1 = 1'b0; tick();

    // Lock: three locked writes by requester 0 while requester 1 waits
    req1 = 1'b1; we1 = 1'b0; addr1 = 2'd1; lock1 = 1'b0;
    req0 = 1'b1; we0 = 1'b1; lock0 = 1'b1; addr0 = 2'd0; wdata0 = 8'h11; settle();
    check("lk_w1_gnt0", 32'(gnt0), 32'd1);
    check("lk_w1_gnt1", 32'(gnt1), 32'd0);
    tick();
    addr0 = 2'd1; wdata0 = 8'h22; settle();
    check("lk_w2_gnt0", 32'(gnt0), 32'd1);
    check("lk_w2_gnt1", 32'(gnt1), 32'd0);
    tick();
    addr0 = 2'd2; wdata0 = 8'h33; lock0 = 1'b0; settle();
    check("lk_w3_gnt0", 32'(gnt0), 32'd1);
    check("lk_w3_gnt1", 32'(gnt1), 32'd0);
    tick();
    we0 = 1'b0; addr0 = 2'd0; settle();
    check("lk_pri1_gnt1", 32'(gnt1), 32'd1);
    check("lk_pri1_gnt0", 32'(gnt0), 32'd0);
    tick();
    check("lk_rd1_rvalid1", 32'(rvalid1), 32'd1);
    check("lk_rd1_rdata", 32'(rdata), 32'h22);
    req1 = 1'b0; settle();
    check("lk_rd0_gnt0", 32'(gnt0), 32'd1);
    tick();
    check("lk_rd0_rvalid0", 32'(rvalid0), 32'd1);
    check("lk_rd0_rdata", 32'(rdata), 32'h11);

    // Lock release by idle: enter LOCK1, then requester 1 drops req
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; lock1 = 1'b1; addr1 = 2'd2; settle();
    check("rel_gnt1", 32'(gnt1), 32'd1);
    tick();
    check("rel_rdata", 32'(rdata), 32'h33);
    req1 = 1'b0; lock1 = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 2'd2; settle();
    check("rel_locked_gnt0", 32'(gnt0), 32'd0);
    tick();
    check("rel_after_gnt0", 32'(gnt0), 32'd1);
    tick();
    check("rel_rvalid0", 32'(rvalid0), 32'd1);
    req0 = 1'b0; tick();

    // Reset in the middle of a read
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd1; wdata0 = 8'h3C; settle();
    check("mid_wr_gnt0", 32'(gnt0), 32'd1);
    tick();
    we0 = 1'b0; settle();
    check("mid_rd_gnt0", 32'(gnt0), 32'd1);
    rst_n = 1'b0; settle();
    check("mid_rst_rvalid0", 32'(rvalid0), 32'd0);
    check("mid_rst_rdata", 32'(rdata), 32'h00);
    tick();
    check("mid_rst_rvalid0_edge", 32'(rvalid0), 32'd0);
    req0 = 1'b0; tick();
    rst_n = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 2'd1; settle();
    check("post_rst_gnt0", 32'(gnt0), 32'd1);
    tick();
    check("post_rst_rvalid0", 32'(rvalid0), 32'd1);
    check("post_rst_rdata", 32'(rdata), 32'h00);
    req0 = 1'b0; tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
